// File: rtl/uart_rx_packet_controller_if.sv
// Handshake bundle between uart_receiver, uart_rx_packet_controller and the
// host command decoder. The controller attaches through the slave modport;
// the environment (receiver + decoder side) drives through the master modport.
interface uart_rx_packet_controller_if;
    logic [7:0] rx_byte_in;
    logic       rx_byte_valid_in;
    logic       rx_byte_done_out;
    logic       rx_rst_n_out;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       pkt_done;
    logic       pkt_ok;
    logic [1:0] pkt_err_code;
    logic       busy;

    modport slave (
        input  rx_byte_in, rx_byte_valid_in, out_ready,
        output rx_byte_done_out, rx_rst_n_out, out_byte, out_valid, out_last,
               pkt_done, pkt_ok, pkt_err_code, busy
    );

    modport master (
        output rx_byte_in, rx_byte_valid_in, out_ready,
        input  rx_byte_done_out, rx_rst_n_out, out_byte, out_valid, out_last,
               pkt_done, pkt_ok, pkt_err_code, busy
    );
endinterface

// File: rtl/uart_rx_packet_controller.sv
// uart_rx_packet_controller
// Acks bytes from the UART receiver, frames them into LEN / payload / CSUM
// packets, streams the payload downstream over valid/ready and reports each
// packet's outcome on pkt_done/pkt_ok/pkt_err_code. A bad length (or a
// mid-packet idle timeout) holds the receiver in reset for RecoverClocks.
//
// Optional feature macro: UART_RX_PKT_TIMEOUT_EN
//   defined   -> idle-line timeout mid-packet (error code 3)
//   undefined -> no timeout logic; a stuck packet persists until rst
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for LEN; a captured LEN is judged in the following cycle
// PAYLOAD | forwarding payload bytes from the hold register downstream
// CSUM    | waiting for the checksum byte; judged in the cycle after capture
// RECOVER | receiver held in reset for RecoverClocks cycles, then IDLE
module uart_rx_packet_controller #(
    parameter int MaxLen        = 64,
    parameter int TimeoutClocks = 25000,
    parameter int RecoverClocks = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_rx_packet_controller_if.slave   bus
);

    localparam int         RcW     = $clog2(RecoverClocks + 1);
    localparam logic [7:0] MaxLenB = 8'(MaxLen);
    localparam logic [RcW-1:0] RcLoad = RcW'(RecoverClocks - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CSUM    = 2'd2,
        S_RECOVER = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic           done_q, done_d;
    logic [7:0]     remaining_q, remaining_d;
    logic [7:0]     sum_q, sum_d;
    logic [RcW-1:0] rc_q, rc_d;

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int             TmW    = $clog2(TimeoutClocks + 1);
    localparam logic [TmW-1:0] TmoMax = TmW'(TimeoutClocks);
    logic [TmW-1:0] tmo_q, tmo_d;
`endif

    logic       capture;
    logic       pkt_done_c;
    logic       pkt_ok_c;
    logic [1:0] err_c;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            remaining_q  <= 8'h00;
            sum_q        <= 8'h00;
            rc_q         <= '0;
`ifdef UART_RX_PKT_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            remaining_q  <= remaining_d;
            sum_q        <= sum_d;
            rc_q         <= rc_d;
`ifdef UART_RX_PKT_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Next-state, capture, running sum and packet status decode.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        remaining_d  = remaining_q;
        sum_d        = sum_q;
        rc_d         = rc_q;
        pkt_done_c   = 1'b0;
        pkt_ok_c     = 1'b0;
        err_c        = 2'd0;
`ifdef UART_RX_PKT_TIMEOUT_EN
        tmo_d        = '0;
`endif

        // The ack cycle itself never captures, so a level-valid byte is
        // taken exactly once even though the receiver drops valid late.
        capture = bus.rx_byte_valid_in && !hold_valid_q && !done_q &&
                  (state_q != S_RECOVER);
        done_d  = capture;
        if (capture) begin
            hold_d       = bus.rx_byte_in;
            hold_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                sum_d       = 8'h00;
                remaining_d = 8'h00;
                if (hold_valid_q) begin
                    hold_valid_d = 1'b0;
                    if (hold_q == 8'h00 || hold_q > MaxLenB) begin
                        pkt_done_c = 1'b1;
                        err_c      = 2'd1;
                        rc_d       = RcLoad;
                        state_d    = S_RECOVER;
                    end else begin
                        remaining_d = hold_q;
                        sum_d       = hold_q;
                        state_d     = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (capture) begin
                    sum_d = sum_q + bus.rx_byte_in;
                end
                if (hold_valid_q && bus.out_ready) begin
                    hold_valid_d = 1'b0;
                    remaining_d  = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (capture) begin
                    sum_d = sum_q + bus.rx_byte_in;
                end
                // Checksum byte is consumed here and never forwarded.
                if (hold_valid_q) begin
                    pkt_done_c   = 1'b1;
                    pkt_ok_c     = (sum_q == 8'h00);
                    err_c        = (sum_q == 8'h00) ? 2'd0 : 2'd2;
                    hold_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_RECOVER: begin
                hold_valid_d = 1'b0;
                if (rc_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rc_d = rc_q - RcW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UART_RX_PKT_TIMEOUT_EN
        // Counts only while the line is expected to deliver a byte; saturates
        // at the terminal value, which immediately aborts the packet.
        if ((state_q == S_PAYLOAD || state_q == S_CSUM) && !hold_valid_q) begin
            if (tmo_q == TmoMax) begin
                pkt_done_c   = 1'b1;
                pkt_ok_c     = 1'b0;
                err_c        = 2'd3;
                hold_valid_d = 1'b0;
                rc_d         = RcLoad;
                state_d      = S_RECOVER;
            end else if (capture) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TmW'(1);
            end
        end
`endif
    end

    // Outputs forced low while rst is asserted so a mid-packet reset never
    // leaks a pulse or a stale payload byte.
    always_comb begin
        bus.rx_byte_done_out = done_q && !rst;
        bus.rx_rst_n_out     = !rst && (state_q != S_RECOVER);
        bus.out_valid        = !rst && (state_q == S_PAYLOAD) && hold_valid_q;
        bus.out_byte         = bus.out_valid ? hold_q : 8'h00;
        bus.out_last         = bus.out_valid && (remaining_q == 8'd1);
        bus.pkt_done         = !rst && pkt_done_c;
        bus.pkt_ok           = bus.pkt_done && pkt_ok_c;
        bus.pkt_err_code     = bus.pkt_done ? err_c : 2'd0;
        bus.busy             = !rst && (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_packet_controller.sv
// Directed bench for uart_rx_packet_controller (default parameters).
module tb_uart_rx_packet_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_packet_controller_if bus ();

    uart_rx_packet_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, written only by the monitor process.
    logic [7:0] obytes[$];
    logic       olast[$];
    int         n_done   = 0;
    int         n_ack    = 0;
    int         n_rstlow = 0;
    logic       last_ok  = 1'b0;
    logic [1:0] last_err = 2'd0;

    // Records payload transfers, packet results, acks and receiver-reset cycles.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            obytes.push_back(bus.out_byte);
            olast.push_back(bus.out_last);
        end
        if (bus.pkt_done === 1'b1) begin
            n_done   <= n_done + 1;
            last_ok  <= bus.pkt_ok;
            last_err <= bus.pkt_err_code;
        end
        if (bus.rx_byte_done_out === 1'b1) n_ack <= n_ack + 1;
        if (bus.rx_rst_n_out === 1'b0) n_rstlow <= n_rstlow + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.rx_byte_in       = b;
        bus.rx_byte_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rx_byte_done_out === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_byte_valid_in = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_done(input int base, input int lim, output int cyc);
        cyc = 0;
        while (n_done == base && cyc < lim) begin
            @(posedge clk);
            cyc++;
        end
        chk("pkt_done_seen", {31'd0, n_done != base}, 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int       cyc;
    int       db;
    int       ob;
    int       ab;
    int       rb;

    initial begin
        rst                  = 1'b1;
        bus.rx_byte_in       = 8'h00;
        bus.rx_byte_valid_in = 1'b0;
        bus.out_ready        = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_rst_n", bus.rx_rst_n_out, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_pkt_done", bus.pkt_done, 1'b0);
        chk("rst_done_out", bus.rx_byte_done_out, 1'b0);
        chk("rst_out_byte", bus.out_byte, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_rx_rst_n", bus.rx_rst_n_out, 1'b1);
        chk("idle_busy", bus.busy, 1'b0);

        // Good packet 03 A1 B2 C3 E7
        db = n_done; ob = obytes.size();
        send_byte(8'h03);
        send_byte(8'hA1);
        @(negedge clk);
        chk("payload_busy", bus.busy, 1'b1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hE7);
        wait_done(db, 50, cyc);
        settle(2);
        chk("good_ndone", n_done - db, 1);
        chk("good_ok", last_ok, 1'b1);
        chk("good_err", last_err, 2'd0);
        chk("good_nbytes", obytes.size() - ob, 3);
        chk("good_b0", obytes[ob], 8'hA1);
        chk("good_b1", obytes[ob+1], 8'hB2);
        chk("good_b2", obytes[ob+2], 8'hC3);
        chk("good_last0", olast[ob], 1'b0);
        chk("good_last2", olast[ob+2], 1'b1);
        chk("good_idle", bus.busy, 1'b0);

        // Bad checksum E6, then a normal packet
        db = n_done; ob = obytes.size();
        send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        send_byte(8'hE6);
        wait_done(db, 50, cyc);
        settle(2);
        chk("csum_ok", last_ok, 1'b0);
        chk("csum_err", last_err, 2'd2);
        chk("csum_nbytes", obytes.size() - ob, 3);
        chk("csum_b2", obytes[ob+2], 8'hC3);
        chk("csum_idle", bus.busy, 1'b0);
        db = n_done; ob = obytes.size();
        send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
        wait_done(db, 50, cyc);
        settle(2);
        chk("after_csum_ok", last_ok, 1'b1);
        chk("after_csum_byte", obytes[ob], 8'h5A);
        chk("after_csum_last", olast[ob], 1'b1);

        // LEN 00 -> bad length, receiver reset for 16 cycles
        db = n_done; rb = n_rstlow;
        send_byte(8'h00);
        wait_done(db, 50, cyc);
        settle(30);
        chk("len0_err", last_err, 2'd1);
        chk("len0_ok", last_ok, 1'b0);
        chk("len0_rstlow", n_rstlow - rb, 16);
        chk("len0_idle", bus.busy, 1'b0);
        chk("len0_rx_rst_n", bus.rx_rst_n_out, 1'b1);

        // LEN 41 (one above MaxLen) -> bad length
        db = n_done; rb = n_rstlow; ob = obytes.size();
        send_byte(8'h41);
        wait_done(db, 50, cyc);
        settle(30);
        chk("len41_err", last_err, 2'd1);
        chk("len41_rstlow", n_rstlow - rb, 16);
        chk("len41_nbytes", obytes.size() - ob, 0);

        // LEN 40 (MaxLen) with payload 01..40, checksum A0
        db = n_done; ob = obytes.size();
        send_byte(8'h40);
        for (int i = 1; i <= 64; i++) send_byte(8'(i));
        send_byte(8'hA0);
        wait_done(db, 50, cyc);
        settle(2);
        chk("max_ok", last_ok, 1'b1);
        chk("max_nbytes", obytes.size() - ob, 64);
        chk("max_lastbyte", obytes[ob+63], 8'h40);
        chk("max_last63", olast[ob+63], 1'b1);
        chk("max_last62", olast[ob+62], 1'b0);

        // Downstream stall on B2 for 5 cycles
        db = n_done; ob = obytes.size();
        send_byte(8'h03);
        send_byte(8'hA1);
        bus.out_ready = 1'b0;
        ab = n_ack;
        send_byte(8'hB2);
        @(posedge clk);
        #1;
        bus.rx_byte_in       = 8'hC3;
        bus.rx_byte_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_byte", bus.out_byte, 8'hB2);
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_noack", bus.rx_byte_done_out, 1'b0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        cyc = 0;
        while (bus.rx_byte_done_out !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_c3_ack", bus.rx_byte_done_out, 1'b1);
        @(posedge clk);
        #1 bus.rx_byte_valid_in = 1'b0;
        send_byte(8'hE7);
        wait_done(db, 50, cyc);
        settle(2);
        chk("stall_ok", last_ok, 1'b1);
        chk("stall_acks", n_ack - ab, 3);
        chk("stall_nbytes", obytes.size() - ob, 3);
        chk("stall_b1", obytes[ob+1], 8'hB2);
        chk("stall_b2", obytes[ob+2], 8'hC3);

        // rst mid-PAYLOAD
        db = n_done;
        bus.out_ready = 1'b0;
        send_byte(8'h03);
        send_byte(8'hA1);
        @(negedge clk);
        chk("midrst_pre_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_byte", bus.out_byte, 8'h00);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_rx_rst_n", bus.rx_rst_n_out, 1'b0);
        chk("midrst_pkt_done", bus.pkt_done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        settle(2);
        chk("midrst_ndone", n_done - db, 0);
        chk("midrst_idle", bus.busy, 1'b0);
        ob = obytes.size();
        send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        send_byte(8'hE7);
        wait_done(db, 50, cyc);
        settle(2);
        chk("midrst_next_ok", last_ok, 1'b1);
        chk("midrst_next_b0", obytes[ob], 8'hA1);

        // Silence after 03 A1
        db = n_done; rb = n_rstlow;
        send_byte(8'h03);
        send_byte(8'hA1);
`ifdef UART_RX_PKT_TIMEOUT_EN
        wait_done(db, 26000, cyc);
        settle(30);
        chk("tmo_err", last_err, 2'd3);
        chk("tmo_ok", last_ok, 1'b0);
        chk("tmo_time", {31'd0, (cyc >= 24990 && cyc <= 25010)}, 32'd1);
        chk("tmo_rstlow", n_rstlow - rb, 16);
        chk("tmo_idle", bus.busy, 1'b0);
`else
        settle(300);
        chk("stuck_busy", bus.busy, 1'b1);
        chk("stuck_ndone", n_done - db, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(2);
        chk("stuck_cleared", bus.busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
